// File: rtl/dma_timing_ctrl_pkg.sv
// Shared types for the 8237 cycle sequencer: bus-cycle states and the channel
// transfer attributes latched for the duration of one service.
package dma_timing_ctrl_pkg;

  typedef enum logic [2:0] {
    SI = 3'd0,
    S0 = 3'd1,
    S1 = 3'd2,
    S2 = 3'd3,
    S3 = 3'd4,
    SW = 3'd5,
    S4 = 3'd6
  } dma_state_t;

  typedef enum logic [1:0] {
    XFER_VERIFY = 2'b00,
    XFER_WRITE  = 2'b01,
    XFER_READ   = 2'b10
  } xfer_type_t;

  typedef enum logic [1:0] {
    MODE_DEMAND = 2'b00,
    MODE_SINGLE = 2'b01,
    MODE_BLOCK  = 2'b10
  } xfer_mode_t;

  // The reserved type code 11 behaves as verify.
  function automatic xfer_type_t toXferType(input logic [1:0] raw);
    xfer_type_t t;
    case (raw)
      2'b01:   t = XFER_WRITE;
      2'b10:   t = XFER_READ;
      default: t = XFER_VERIFY;
    endcase
    return t;
  endfunction

  // The reserved mode code 11 behaves as single.
  function automatic xfer_mode_t toXferMode(input logic [1:0] raw);
    xfer_mode_t m;
    case (raw)
      2'b00:   m = MODE_DEMAND;
      2'b10:   m = MODE_BLOCK;
      default: m = MODE_SINGLE;
    endcase
    return m;
  endfunction

  function automatic logic inWordCycle(input dma_state_t s);
    return (s == S1) || (s == S2) || (s == S3) || (s == SW) || (s == S4);
  endfunction

endpackage

// File: rtl/dma_strobe_gen.sv
// Combinational decode of bus state and transfer type into the four active-low
// command strobes; zero latency, no flow control.
module dma_strobe_gen
  import dma_timing_ctrl_pkg::*;
(
  input  dma_state_t state,
  input  xfer_type_t xferType,
  output logic       memrN,
  output logic       memwN,
  output logic       iorN,
  output logic       iowN
);

  logic readPhase;
  logic writePhase;

  always_comb begin
    readPhase  = (state == S2) || (state == S3) || (state == SW) || (state == S4);
    writePhase = (state == S3) || (state == SW) || (state == S4);
    memrN = 1'b1;
    memwN = 1'b1;
    iorN  = 1'b1;
    iowN  = 1'b1;
    // Verify cycles run the full timing but never touch the bus commands.
    case (xferType)
      XFER_READ: begin
        memrN = ~readPhase;
        iowN  = ~writePhase;
      end
      XFER_WRITE: begin
        iorN  = ~readPhase;
        memwN = ~writePhase;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dma_timing_ctrl.sv
// 8237 transfer sequencer: HRQ/HLDA handshake then SI/S0/S1/S2/S3/SW/S4 word cycles.
// Outputs decoded from registered state; READY=0 stretches a word through SW, HLDA loss aborts.
module dma_timing_ctrl
  import dma_timing_ctrl_pkg::*;
#(
  parameter int NUM_CH = 4
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic                      req_valid,
  input  logic [$clog2(NUM_CH)-1:0] req_ch,
  input  logic [1:0]                xfer_type,
  input  logic [1:0]                xfer_mode,
  input  logic                      dreq_active,
  input  logic                      hi_addr_chg,
  input  logic                      tc,
  input  logic                      HLDA,
  input  logic                      READY,
  input  logic                      EOP_n_in,
  output logic                      HRQ,
  output logic                      AEN,
  output logic                      ADSTB,
  output logic                      dack_valid,
  output logic [$clog2(NUM_CH)-1:0] dack_ch,
  output logic                      MEMR_n,
  output logic                      MEMW_n,
  output logic                      IOR_n,
  output logic                      IOW_n,
  output logic                      EOP_n_out,
  output logic                      addr_upd,
  output logic                      grant,
  output logic                      busy
);

  dma_state_t                state;
  dma_state_t                nextState;
  logic [$clog2(NUM_CH)-1:0] curCh;
  xfer_type_t                curType;
  xfer_mode_t                curMode;
  logic                      eopSeen;
  logic                      grantDone;
  logic                      wordCycle;
  logic                      endService;
  logic                      keepGoing;

  assign wordCycle = inWordCycle(state);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= SI;
    end else begin
      state <= nextState;
    end
  end

  // Channel attributes are frozen from SI until the service returns to SI.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      curCh   <= '0;
      curType <= XFER_VERIFY;
      curMode <= MODE_DEMAND;
    end else if (state == SI && req_valid) begin
      curCh   <= req_ch;
      curType <= toXferType(xfer_type);
      curMode <= toXferMode(xfer_mode);
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      eopSeen   <= 1'b0;
      grantDone <= 1'b0;
    end else if (state == SI) begin
      eopSeen   <= 1'b0;
      grantDone <= 1'b0;
    end else begin
      if (wordCycle && !EOP_n_in) begin
        eopSeen <= 1'b1;
      end
      if (state == S1) begin
        grantDone <= 1'b1;
      end
    end
  end

  // An EOP arriving in S4 itself still ends the service after this word.
  assign endService = tc || eopSeen || !EOP_n_in;
  assign keepGoing  = (curMode == MODE_BLOCK) || ((curMode == MODE_DEMAND) && dreq_active);

  always_comb begin
    nextState = state;
    case (state)
      SI: begin
        if (req_valid) nextState = S0;
      end
      S0: begin
        if (HLDA) begin
          nextState = S1;
        end else if (!req_valid) begin
          nextState = SI;
        end
      end
      S1: nextState = S2;
      S2: nextState = S3;
      S3: nextState = READY ? S4 : SW;
      SW: nextState = READY ? S4 : SW;
      S4: begin
        if (endService || !keepGoing) begin
          nextState = SI;
        end else begin
          nextState = hi_addr_chg ? S1 : S2;
        end
      end
      default: nextState = SI;
    endcase
    // Losing the bus mid-word abandons the word without an address update.
    if (wordCycle && !HLDA) begin
      nextState = SI;
    end
  end

  assign busy       = (state != SI);
  assign HRQ        = busy;
  assign AEN        = wordCycle;
  assign dack_valid = wordCycle;
  assign dack_ch    = curCh;
  assign ADSTB      = (state == S1);
  assign grant      = (state == S1) && !grantDone;
  assign addr_upd   = (state == S4);
  assign EOP_n_out  = !((state == S4) && tc);

  dma_strobe_gen strobeGen (
    .state    (state),
    .xferType (curType),
    .memrN    (MEMR_n),
    .memwN    (MEMW_n),
    .iorN     (IOR_n),
    .iowN     (IOW_n)
  );

endmodule

// File: tb/tb_dma_timing_ctrl.sv
// Cycle-table bench for dma_timing_ctrl: each row drives one cycle of inputs and
// names the outputs expected once the following rising edge has been taken.
`timescale 1ns/1ps
module tb_dma_timing_ctrl;

  logic       CLK;
  logic       RESET;
  logic       req_valid;
  logic [1:0] req_ch;
  logic [1:0] xfer_type;
  logic [1:0] xfer_mode;
  logic       dreq_active;
  logic       hi_addr_chg;
  logic       tc;
  logic       HLDA;
  logic       READY;
  logic       EOP_n_in;
  logic       HRQ;
  logic       AEN;
  logic       ADSTB;
  logic       dack_valid;
  logic [1:0] dack_ch;
  logic       MEMR_n;
  logic       MEMW_n;
  logic       IOR_n;
  logic       IOW_n;
  logic       EOP_n_out;
  logic       addr_upd;
  logic       grant;
  logic       busy;

  dma_timing_ctrl #(.NUM_CH(4)) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .req_valid   (req_valid),
    .req_ch      (req_ch),
    .xfer_type   (xfer_type),
    .xfer_mode   (xfer_mode),
    .dreq_active (dreq_active),
    .hi_addr_chg (hi_addr_chg),
    .tc          (tc),
    .HLDA        (HLDA),
    .READY       (READY),
    .EOP_n_in    (EOP_n_in),
    .HRQ         (HRQ),
    .AEN         (AEN),
    .ADSTB       (ADSTB),
    .dack_valid  (dack_valid),
    .dack_ch     (dack_ch),
    .MEMR_n      (MEMR_n),
    .MEMW_n      (MEMW_n),
    .IOR_n       (IOR_n),
    .IOW_n       (IOW_n),
    .EOP_n_out   (EOP_n_out),
    .addr_upd    (addr_upd),
    .grant       (grant),
    .busy        (busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Output vector: {HRQ,AEN,ADSTB,dack_valid, MEMR_n,MEMW_n,IOR_n,IOW_n, EOP_n_out,addr_upd,grant,busy}
  localparam logic [11:0] E_IDLE = 12'b0000_1111_1000;
  localparam logic [11:0] E_S0   = 12'b1000_1111_1001;
  localparam logic [11:0] E_S1G  = 12'b1111_1111_1011;
  localparam logic [11:0] E_S1   = 12'b1111_1111_1001;
  localparam logic [11:0] E_R2   = 12'b1101_0111_1001;
  localparam logic [11:0] E_R3   = 12'b1101_0110_1001;
  localparam logic [11:0] E_R4   = 12'b1101_0110_1101;
  localparam logic [11:0] E_W2   = 12'b1101_1101_1001;
  localparam logic [11:0] E_W3   = 12'b1101_1001_1001;
  localparam logic [11:0] E_W4   = 12'b1101_1001_1101;
  localparam logic [11:0] E_W4T  = 12'b1101_1001_0101;
  localparam logic [11:0] E_V2   = 12'b1101_1111_1001;
  localparam logic [11:0] E_V4   = 12'b1101_1111_1101;

  // reqBits = {req_valid,req_ch,xfer_type,xfer_mode}; ctlBits = {dreq,hi_addr_chg,tc,HLDA,READY,EOP_n_in}
  typedef struct {
    string       tag;
    logic [6:0]  reqBits;
    logic [5:0]  ctlBits;
    logic [11:0] expOut;
    logic [1:0]  expCh;
  } vec_t;

  typedef struct {
    string       tag;
    logic [11:0] out;
    logic [1:0]  ch;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t r(input string tag, input logic [6:0] rq, input logic [5:0] ctl,
                             input logic [11:0] eo, input logic [1:0] ec);
    vec_t x;
    x.tag     = tag;
    x.reqBits = rq;
    x.ctlBits = ctl;
    x.expOut  = eo;
    x.expCh   = ec;
    return x;
  endfunction

  function automatic logic [11:0] obs();
    return {HRQ, AEN, ADSTB, dack_valid, MEMR_n, MEMW_n, IOR_n, IOW_n,
            EOP_n_out, addr_upd, grant, busy};
  endfunction

  task automatic drive(input logic [6:0] rq, input logic [5:0] ctl);
    {req_valid, req_ch, xfer_type, xfer_mode} = rq;
    {dreq_active, hi_addr_chg, tc, HLDA, READY, EOP_n_in} = ctl;
  endtask

  task automatic checkOut(input string tag, input logic [11:0] expOut, input logic [1:0] expCh);
    logic [11:0] got;
    got = obs();
    checks++;
    if (got !== expOut) begin
      errors++;
      $display("FAIL %s outputs: got %b, required %b", tag, got, expOut);
    end
    checks++;
    if (dack_ch !== expCh) begin
      errors++;
      $display("FAIL %s dack_ch: got %0d, required %0d", tag, dack_ch, expCh);
    end
  endtask

  task automatic cycle();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach its end within 100000 ns");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t e;
    RESET = 1'b0;
    drive(7'b0, 6'b000011);

    // Single read on ch2, HLDA returned two cycles after HRQ; request inputs change mid-service.
    vecs.push_back(r("rdS", 7'b1_10_10_01, 6'b000011, E_S0,   2'd2));
    vecs.push_back(r("rdS", 7'b1_10_10_01, 6'b000011, E_S0,   2'd2));
    vecs.push_back(r("rdS", 7'b1_10_10_01, 6'b000111, E_S1G,  2'd2));
    vecs.push_back(r("rdS", 7'b0_00_00_00, 6'b000111, E_R2,   2'd2));
    vecs.push_back(r("rdS", 7'b0_00_00_00, 6'b000111, E_R3,   2'd2));
    vecs.push_back(r("rdS", 7'b0_00_00_00, 6'b000111, E_R4,   2'd2));
    vecs.push_back(r("rdS", 7'b0_00_00_00, 6'b000111, E_IDLE, 2'd2));
    vecs.push_back(r("rdS", 7'b0_00_00_00, 6'b000011, E_IDLE, 2'd2));
    // Request withdrawn in S0 before HLDA.
    vecs.push_back(r("wdr", 7'b1_11_01_01, 6'b000011, E_S0,   2'd3));
    vecs.push_back(r("wdr", 7'b0_11_01_01, 6'b000011, E_IDLE, 2'd3));
    // Block write on ch1, three words, tc on word 3; competing request on ch3 is ignored.
    vecs.push_back(r("blkW", 7'b1_01_01_10, 6'b000011, E_S0,   2'd1));
    vecs.push_back(r("blkW", 7'b1_11_10_01, 6'b000111, E_S1G,  2'd1));
    vecs.push_back(r("blkW", 7'b1_11_10_01, 6'b000111, E_W2,   2'd1));
    vecs.push_back(r("blkW", 7'b1_11_10_01, 6'b000111, E_W3,   2'd1));
    vecs.push_back(r("blkW", 7'b1_11_10_01, 6'b000111, E_W4,   2'd1));
    vecs.push_back(r("blkW", 7'b1_11_10_01, 6'b000111, E_W2,   2'd1));
    vecs.push_back(r("blkW", 7'b1_11_10_01, 6'b000111, E_W3,   2'd1));
    vecs.push_back(r("blkW", 7'b1_11_10_01, 6'b000111, E_W4,   2'd1));
    vecs.push_back(r("blkW", 7'b1_11_10_01, 6'b000111, E_W2,   2'd1));
    vecs.push_back(r("blkW", 7'b1_11_10_01, 6'b001111, E_W3,   2'd1));
    vecs.push_back(r("blkW", 7'b1_11_10_01, 6'b001111, E_W4T,  2'd1));
    vecs.push_back(r("blkW", 7'b0_00_00_00, 6'b001111, E_IDLE, 2'd1));
    vecs.push_back(r("blkW", 7'b0_00_00_00, 6'b000011, E_IDLE, 2'd1));
    // READY low on the S3 and first SW samples: two wait states.
    vecs.push_back(r("rdy", 7'b1_00_10_01, 6'b000011, E_S0,   2'd0));
    vecs.push_back(r("rdy", 7'b0_00_00_00, 6'b000111, E_S1G,  2'd0));
    vecs.push_back(r("rdy", 7'b0_00_00_00, 6'b000111, E_R2,   2'd0));
    vecs.push_back(r("rdy", 7'b0_00_00_00, 6'b000101, E_R3,   2'd0));
    vecs.push_back(r("rdy", 7'b0_00_00_00, 6'b000101, E_R3,   2'd0));
    vecs.push_back(r("rdy", 7'b0_00_00_00, 6'b000101, E_R3,   2'd0));
    vecs.push_back(r("rdy", 7'b0_00_00_00, 6'b000111, E_R4,   2'd0));
    vecs.push_back(r("rdy", 7'b0_00_00_00, 6'b000111, E_IDLE, 2'd0));
    // Demand write on ch3: upper address change re-enters S1 without grant; DREQ drops in word 2.
    vecs.push_back(r("dmd", 7'b1_11_01_00, 6'b100011, E_S0,   2'd3));
    vecs.push_back(r("dmd", 7'b0_00_00_00, 6'b100111, E_S1G,  2'd3));
    vecs.push_back(r("dmd", 7'b0_00_00_00, 6'b100111, E_W2,   2'd3));
    vecs.push_back(r("dmd", 7'b0_00_00_00, 6'b100111, E_W3,   2'd3));
    vecs.push_back(r("dmd", 7'b0_00_00_00, 6'b100111, E_W4,   2'd3));
    vecs.push_back(r("dmd", 7'b0_00_00_00, 6'b110111, E_S1,   2'd3));
    vecs.push_back(r("dmd", 7'b0_00_00_00, 6'b000111, E_W2,   2'd3));
    vecs.push_back(r("dmd", 7'b0_00_00_00, 6'b000111, E_W3,   2'd3));
    vecs.push_back(r("dmd", 7'b0_00_00_00, 6'b000111, E_W4,   2'd3));
    vecs.push_back(r("dmd", 7'b0_00_00_00, 6'b000111, E_IDLE, 2'd3));
    vecs.push_back(r("dmd", 7'b0_00_00_00, 6'b000011, E_IDLE, 2'd3));
    // External EOP pulsed in S2 of a block read: word completes, service ends.
    vecs.push_back(r("eop", 7'b1_10_10_10, 6'b000011, E_S0,   2'd2));
    vecs.push_back(r("eop", 7'b0_00_00_00, 6'b100111, E_S1G,  2'd2));
    vecs.push_back(r("eop", 7'b0_00_00_00, 6'b100111, E_R2,   2'd2));
    vecs.push_back(r("eop", 7'b0_00_00_00, 6'b100110, E_R3,   2'd2));
    vecs.push_back(r("eop", 7'b0_00_00_00, 6'b100111, E_R4,   2'd2));
    vecs.push_back(r("eop", 7'b0_00_00_00, 6'b100111, E_IDLE, 2'd2));
    vecs.push_back(r("eop", 7'b0_00_00_00, 6'b000011, E_IDLE, 2'd2));
    // HLDA lost in S3: straight to SI, no address update.
    vecs.push_back(r("hld", 7'b1_01_10_01, 6'b000011, E_S0,   2'd1));
    vecs.push_back(r("hld", 7'b0_00_00_00, 6'b000111, E_S1G,  2'd1));
    vecs.push_back(r("hld", 7'b0_00_00_00, 6'b000111, E_R2,   2'd1));
    vecs.push_back(r("hld", 7'b0_00_00_00, 6'b000111, E_R3,   2'd1));
    vecs.push_back(r("hld", 7'b0_00_00_00, 6'b000011, E_IDLE, 2'd1));
    vecs.push_back(r("hld", 7'b0_00_00_00, 6'b000011, E_IDLE, 2'd1));
    // Reserved codes: type 11 is verify (no strobes), mode 11 is single (ends despite DREQ).
    vecs.push_back(r("vfy", 7'b1_00_11_11, 6'b000011, E_S0,   2'd0));
    vecs.push_back(r("vfy", 7'b0_00_00_00, 6'b000111, E_S1G,  2'd0));
    vecs.push_back(r("vfy", 7'b0_00_00_00, 6'b000111, E_V2,   2'd0));
    vecs.push_back(r("vfy", 7'b0_00_00_00, 6'b000111, E_V2,   2'd0));
    vecs.push_back(r("vfy", 7'b0_00_00_00, 6'b000111, E_V4,   2'd0));
    vecs.push_back(r("vfy", 7'b0_00_00_00, 6'b100111, E_IDLE, 2'd0));
    vecs.push_back(r("vfy", 7'b0_00_00_00, 6'b000011, E_IDLE, 2'd0));

    #1 RESET = 1'b1;
    #2 checkOut("reset", E_IDLE, 2'd0);
    @(negedge CLK);
    RESET = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].reqBits, vecs[i].ctlBits);
      e.tag = $sformatf("%s[%0d]", vecs[i].tag, i);
      e.out = vecs[i].expOut;
      e.ch  = vecs[i].expCh;
      sb.push_back(e);
      cycle();
      e = sb.pop_front();
      checkOut(e.tag, e.out, e.ch);
    end

    // Reset asserted in the middle of S2 of a block read on ch3.
    drive(7'b1_11_10_10, 6'b000011);
    cycle();
    checkOut("rstSeq S0", E_S0, 2'd3);
    drive(7'b0_00_00_00, 6'b000111);
    cycle();
    checkOut("rstSeq S1", E_S1G, 2'd3);
    cycle();
    checkOut("rstSeq S2", E_R2, 2'd3);
    #2 RESET = 1'b1;
    #1 checkOut("rstSeq async", E_IDLE, 2'd0);
    drive(7'b0_00_00_00, 6'b000011);
    cycle();
    checkOut("rstSeq held", E_IDLE, 2'd0);
    RESET = 1'b0;
    cycle();
    checkOut("rstSeq released", E_IDLE, 2'd0);
    drive(7'b1_01_00_01, 6'b000011);
    cycle();
    checkOut("rstSeq newReq", E_S0, 2'd1);
    drive(7'b0_00_00_00, 6'b000011);
    cycle();
    checkOut("rstSeq withdraw", E_IDLE, 2'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
